// File: rtl/debug_dump_receiver.sv
// Receive-side engine for the MIPS debug dump stream: reassembles UART bytes into
// 32-bit words, stores them in a capture buffer and checks the frame XOR checksum.
module debug_dump_receiver #(
  parameter int          N_WORDS        = 66,
  parameter int          ADDR_W         = 7,
  parameter logic [7:0]  SYNC_BYTE      = 8'hA5,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [7:0]        i_rx_data,
  input  logic              i_rx_done,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [31:0]       o_rd_data,
  output logic              o_busy,
  output logic              o_frame_valid,
  output logic              o_frame_error,
  output logic [ADDR_W-1:0] o_word_count
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_DATA  = 2'd1;
  localparam logic [1:0] ST_CHECK = 2'd2;

  localparam int              TW        = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0]   TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [ADDR_W-1:0] LAST_WORD = ADDR_W'(N_WORDS - 1);

  logic [1:0]        state;
  logic [1:0]        byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic [7:0]        csum;
  logic [23:0]       sr;
  logic [TW-1:0]     to_cnt;
  logic [31:0]       mem [0:N_WORDS-1];

  logic        wr_en;
  logic [31:0] wr_word;

  always_comb begin
    wr_en   = (state == ST_DATA) && i_rx_done && (byte_idx == 2'd3);
    wr_word = {sr, i_rx_data};
  end

  // Buffer has no reset; nonblocking write gives old-data on read/write collision.
  always_ff @(posedge i_clk) begin
    if (wr_en) mem[word_idx] <= wr_word;
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state         <= ST_IDLE;
      byte_idx      <= '0;
      word_idx      <= '0;
      csum          <= '0;
      sr            <= '0;
      to_cnt        <= '0;
      o_rd_data     <= '0;
      o_busy        <= 1'b0;
      o_frame_valid <= 1'b0;
      o_frame_error <= 1'b0;
      o_word_count  <= '0;
    end else begin
      o_rd_data <= (32'(i_rd_addr) < N_WORDS) ? mem[i_rd_addr] : '0;

      case (state)
        ST_IDLE: begin
          to_cnt <= '0;
          if (i_rx_done && i_rx_data == SYNC_BYTE) begin
            state         <= ST_DATA;
            byte_idx      <= '0;
            word_idx      <= '0;
            csum          <= '0;
            o_word_count  <= '0;
            o_frame_valid <= 1'b0;
            o_frame_error <= 1'b0;
            o_busy        <= 1'b1;
          end
        end

        ST_DATA: begin
          if (i_rx_done) begin
            to_cnt   <= '0;
            sr       <= {sr[15:0], i_rx_data};
            csum     <= csum ^ i_rx_data;
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              word_idx     <= word_idx + 1'b1;
              o_word_count <= o_word_count + 1'b1;
              if (word_idx == LAST_WORD) state <= ST_CHECK;
            end
          end else if (to_cnt == TO_LAST) begin
            o_frame_error <= 1'b1;
            o_busy        <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        ST_CHECK: begin
          if (i_rx_done) begin
            to_cnt <= '0;
            if (i_rx_data == csum) o_frame_valid <= 1'b1;
            else                   o_frame_error <= 1'b1;
            o_busy <= 1'b0;
            state  <= ST_IDLE;
          end else if (to_cnt == TO_LAST) begin
            o_frame_error <= 1'b1;
            o_busy        <= 1'b0;
            state         <= ST_IDLE;
          end else begin
            to_cnt <= to_cnt + 1'b1;
          end
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_debug_dump_receiver.sv
// Scoreboard bench for debug_dump_receiver: frames, checksum errors, garbage,
// timeout and mid-frame reset, with capture-buffer reads checked at 1-cycle latency.
module tb_debug_dump_receiver;

  localparam int N_WORDS = 66;
  localparam int ADDR_W  = 7;
  localparam int TO      = 50;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [7:0]        rx_data;
  logic              rx_done;
  logic [ADDR_W-1:0] rd_addr;
  logic [31:0]       rd_data;
  logic              busy, frame_valid, frame_error;
  logic [ADDR_W-1:0] word_count;

  always #5 clk = ~clk;

  debug_dump_receiver #(
    .N_WORDS(N_WORDS),
    .ADDR_W(ADDR_W),
    .SYNC_BYTE(8'hA5),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .i_clk(clk),
    .i_rst(rst_n),
    .i_rx_data(rx_data),
    .i_rx_done(rx_done),
    .i_rd_addr(rd_addr),
    .o_rd_data(rd_data),
    .o_busy(busy),
    .o_frame_valid(frame_valid),
    .o_frame_error(frame_error),
    .o_word_count(word_count)
  );

  typedef struct {
    logic valid;
    logic err;
    int   wc;
  } status_t;

  status_t     st_q[$];
  logic [31:0] rd_q[$];
  logic [31:0] words[N_WORDS];
  logic [7:0]  fb[$];
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_default_words();
    words[0] = 32'h0000_0040;
    words[1] = 32'h0000_001F;
    for (int i = 0; i < 32; i++) begin
      words[2 + i]  = 32'(i);
      words[34 + i] = 32'h100 + 32'(i);
    end
  endtask

  // Sync, MSB-first payload, then XOR of payload bytes (optionally corrupted).
  task automatic build_frame(input logic corrupt);
    logic [7:0] cs;
    logic [7:0] b;
    cs = 8'h00;
    fb.delete();
    fb.push_back(8'hA5);
    for (int w = 0; w < N_WORDS; w++) begin
      for (int k = 3; k >= 0; k--) begin
        b = words[w][8*k +: 8];
        fb.push_back(b);
        cs = cs ^ b;
      end
    end
    fb.push_back(corrupt ? (cs ^ 8'h01) : cs);
  endtask

  task automatic send_byte(input logic [7:0] b);
    @(negedge clk);
    rx_data = b;
    rx_done = 1'b1;
    @(negedge clk);
    rx_done = 1'b0;
  endtask

  task automatic send_range(input int lo, input int hi);
    for (int i = lo; i <= hi; i++) send_byte(fb[i]);
  endtask

  task automatic expect_status(input logic v, input logic e, input int wc);
    status_t s;
    s.valid = v;
    s.err   = e;
    s.wc    = wc;
    st_q.push_back(s);
  endtask

  task automatic finish_frame(input string tag);
    status_t s;
    int n;
    n = 0;
    while (busy && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_busy"}, 32'(busy), 32'd0);
    s = st_q.pop_front();
    check({tag, "_valid"}, 32'(frame_valid), 32'(s.valid));
    check({tag, "_error"}, 32'(frame_error), 32'(s.err));
    check({tag, "_wc"}, 32'(word_count), 32'(s.wc));
  endtask

  task automatic read_check(input int a, input logic [31:0] exp);
    @(negedge clk);
    rd_addr = 7'(a);
    rd_q.push_back(exp);
    @(negedge clk);
    check($sformatf("rd[%0d]", a), rd_data, rd_q.pop_front());
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_valid"}, 32'(frame_valid), 32'd0);
    check({tag, "_error"}, 32'(frame_error), 32'd0);
    check({tag, "_wc"}, 32'(word_count), 32'd0);
    check({tag, "_rd"}, rd_data, 32'd0);
  endtask

  initial begin
    int first;
    logic [7:0] garbage[3];
    garbage[0] = 8'h00;
    garbage[1] = 8'hFF;
    garbage[2] = 8'h3C;

    rst_n   = 1'b0;
    rx_data = 8'h00;
    rx_done = 1'b0;
    rd_addr = '0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // Garbage before sync, then a good frame.
    set_default_words();
    build_frame(1'b0);
    foreach (garbage[i]) begin
      send_byte(garbage[i]);
      check($sformatf("garbage%0d_busy", i), 32'(busy), 32'd0);
    end
    send_byte(fb[0]);
    check("sync_busy", 32'(busy), 32'd1);
    expect_status(1'b1, 1'b0, N_WORDS);
    send_range(1, fb.size() - 1);
    finish_frame("good1");
    for (int a = 0; a < N_WORDS; a++) read_check(a, words[a]);
    read_check(100, 32'h0);
    read_check(127, 32'h0);

    // Corrupted checksum, then a good frame clears the error.
    build_frame(1'b1);
    expect_status(1'b0, 1'b1, N_WORDS);
    send_range(0, fb.size() - 1);
    finish_frame("badcs");
    build_frame(1'b0);
    expect_status(1'b1, 1'b0, N_WORDS);
    send_range(0, fb.size() - 1);
    finish_frame("good2");

    // Sync value as payload is stored, no resync.
    words[0] = 32'hA5A5_A5A5;
    words[7] = 32'h00A5_A500;
    build_frame(1'b0);
    expect_status(1'b1, 1'b0, N_WORDS);
    send_range(0, fb.size() - 1);
    finish_frame("a5pay");
    read_check(0, 32'hA5A5_A5A5);
    read_check(7, 32'h00A5_A500);
    read_check(65, 32'h0000_011F);

    // Timeout after 10 payload bytes.
    set_default_words();
    build_frame(1'b0);
    send_range(0, 10);
    check("to_wc", 32'(word_count), 32'd2);
    first = -1;
    for (int k = 1; k <= TO + 10; k++) begin
      @(negedge clk);
      if (frame_error) begin
        first = k;
        break;
      end
    end
    check("to_cycle", 32'(first), 32'(TO));
    check("to_busy", 32'(busy), 32'd0);
    check("to_valid", 32'(frame_valid), 32'd0);
    check("to_wc_end", 32'(word_count), 32'd2);

    // Byte arriving on the terminal-count cycle is accepted.
    send_range(0, 4);
    repeat (TO - 2) @(negedge clk);
    send_byte(fb[5]);
    check("coinc_error", 32'(frame_error), 32'd0);
    check("coinc_busy", 32'(busy), 32'd1);
    expect_status(1'b1, 1'b0, N_WORDS);
    send_range(6, fb.size() - 1);
    finish_frame("coinc");

    // Reset mid-frame, then a clean frame.
    words[10] = 32'hDEAD_BEEF;
    build_frame(1'b0);
    send_range(0, 44);
    check("mid_wc", 32'(word_count), 32'd11);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    expect_status(1'b1, 1'b0, N_WORDS);
    send_range(0, fb.size() - 1);
    finish_frame("after_rst");
    read_check(10, 32'hDEAD_BEEF);
    read_check(1, 32'h0000_001F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
